axi_lite_cmd_master: RTL and testbench
======================================

# axi_lite_cmd_master

AXI4-Lite master that turns single-beat register commands from a local command port into AXI4-Lite write or read transactions. It is the initiator for the `axi_cfg_regs` slave. It is used by the bring-up sequencer and the testbench to program and read back the character-select, debug and direct-control registers without the PS. Exactly one transaction is outstanding at a time. Every result is returned on a response port that supports backpressure.

## Interface
Parameters:
- C_M_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_M_AXI_ADDR_WIDTH, 9: byte address width.

Ports:
- M_AXI_ACLK  in  1  sole clock.
- M_AXI_ARESETN  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP, unchanged.
- M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY: write channels (out/out/in, out/out/out/in, in/in/out).
- M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: read channels (out/out/in, in/in/in/out).

## Operation
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP. All outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - A handshake captures addr, wdata, wstrb and write.
  - Next state is WR_ADDR_DATA for a write, RD_ADDR for a read.
- WR_ADDR_DATA:
  - AWVALID and WVALID are asserted together.
  - Each valid drops independently after its own handshake. AW and W may complete in either order or in the same cycle.
  - Go to WR_RESP once both have completed.
- WR_RESP: BREADY = 1. On the B handshake, latch BRESP, set rsp_rdata = 0 and go to RSP.
- RD_ADDR: ARVALID = 1. On the AR handshake, go to RD_DATA.
- RD_DATA: RREADY = 1. On the R handshake, latch RDATA and RRESP, then go to RSP.
- RSP:
  - rsp_valid = 1; rsp_* are held stable until the rsp_ready handshake.
  - Then go to IDLE.
- Valid outputs are never withdrawn before their handshake completes.
- AWADDR, WDATA, WSTRB and ARADDR stay stable while their valid is high.
- Non-OKAY responses are passed through unchanged. No retry is attempted.
- Commands presented while cmd_ready = 0 are ignored; the caller holds cmd_valid.

## Timing
- Reset state (asynchronous, while M_AXI_ARESETN = 0):
  - all AXI valid/ready outputs, cmd_ready and rsp_valid are 0;
  - address, data and rsp_* registers are 0;
  - the FSM is in IDLE.
- cmd_ready rises in the first clock after reset release.
- Reset asserted mid-transaction aborts the transaction at once. The command is lost and no response is generated.
- Cycle numbering, command handshake at edge N:
  - AWVALID/WVALID or ARVALID are high from N+1.
  - A channel valid drops in the cycle after its handshake edge.
  - BREADY/RREADY rise in the cycle after the last address/data handshake.
  - rsp_valid rises in the cycle after the B/R handshake.
  - cmd_ready rises in the cycle after the rsp handshake.
- Zero-wait slave with rsp_ready held high gives a 4-cycle loop: command to next cmd_ready.
- BVALID or RVALID arriving before BREADY/RREADY is held by the slave and is accepted as soon as the ready rises.

## Configuration
- AXI_LITE_CMD_MASTER_ERR_CNT_EN defined:
  - adds output err_count [7:0].
  - Reset value 0.
  - Increments by 1 on each B or R handshake whose resp is not 2'b00.
  - Saturates at 255.
- Undefined: the err_count port and its counter do not exist; all other behaviour is identical.

## Test plan
- Write, zero-wait slave:
  - cmd write addr 0x004, data 0x00000003, strb 0xF;
  - AW and W both valid at N+1 with those values;
  - rsp_valid at N+3 with rsp_write = 1, resp 00, rdata 0.
- Read, slave returns 0xDEADBEEF after 3 wait cycles on R:
  - ARADDR = 0x008, held until ARREADY;
  - rsp_rdata = 0xDEADBEEF, resp 00, rsp_write = 0.
- Skewed write:
  - AWREADY delayed 5 cycles, WREADY immediate;
  - WVALID drops after 1 cycle, AWVALID stays high until its handshake;
  - BREADY rises only after both handshakes.
- Error response: slave returns BRESP = 2'b10 three times:
  - rsp_resp = 10 each time;
  - with AXI_LITE_CMD_MASTER_ERR_CNT_EN, err_count = 3.
- Backpressure:
  - rsp_ready held low 10 cycles;
  - rsp_* stable and cmd_ready = 0 throughout;
  - a cmd_valid held during this time is accepted only after the rsp handshake.
- Reset mid-read, asserted while ARVALID = 1:
  - all outputs are 0 immediately;
  - cmd_ready = 1 in the first cycle after release;
  - no rsp_valid is ever produced for the aborted command.

Source files
------------

// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a register slave.
// Signal names follow the usual M_AXI_* naming seen from the master side.
interface axi_lite_cmd_master_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic [AW-1:0]   M_AXI_AWADDR;
  logic            M_AXI_AWVALID;
  logic            M_AXI_AWREADY;
  logic [DW-1:0]   M_AXI_WDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic            M_AXI_WVALID;
  logic            M_AXI_WREADY;
  logic [1:0]      M_AXI_BRESP;
  logic            M_AXI_BVALID;
  logic            M_AXI_BREADY;
  logic [AW-1:0]   M_AXI_ARADDR;
  logic            M_AXI_ARVALID;
  logic            M_AXI_ARREADY;
  logic [DW-1:0]   M_AXI_RDATA;
  logic [1:0]      M_AXI_RRESP;
  logic            M_AXI_RVALID;
  logic            M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a local cmd/rsp port.
// Define AXI_LITE_CMD_MASTER_ERR_CNT_EN to add the err_count output.
module axi_lite_cmd_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 9
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  axi_lite_cmd_master_if.master           m_axi
`ifdef AXI_LITE_CMD_MASTER_ERR_CNT_EN
  ,
  output logic [7:0]                      err_count
`endif
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  state_t          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_write_q, rsp_write_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic            err_hit;

  // Next-state and next-output logic; every output is a register.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    err_hit     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          rsp_write_d = cmd_write;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR_ADDR_DATA: begin
        awvalid_d = awvalid_q && !m_axi.M_AXI_AWREADY;
        wvalid_d  = wvalid_q && !m_axi.M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi.M_AXI_BVALID) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi.M_AXI_BRESP;
          err_hit     = (m_axi.M_AXI_BRESP != 2'b00);
          state_d     = RSP;
        end
      end
      RD_ADDR: begin
        if (m_axi.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi.M_AXI_RVALID) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axi.M_AXI_RDATA;
          rsp_resp_d  = m_axi.M_AXI_RRESP;
          err_hit     = (m_axi.M_AXI_RRESP != 2'b00);
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef AXI_LITE_CMD_MASTER_ERR_CNT_EN
  logic [7:0] err_q, err_d;

  // Saturating count of non-OKAY B/R responses.
  always_comb begin
    err_d = err_q;
    if (err_hit && err_q != 8'hFF)
      err_d = err_q + 8'd1;
  end

  // Error counter register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN)
      err_q <= '0;
    else
      err_q <= err_d;
  end

  assign err_count = err_q;
`else
  logic unused_err;
  assign unused_err = err_hit;
`endif

  assign cmd_ready           = cmd_ready_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_write           = rsp_write_q;
  assign rsp_rdata           = rsp_rdata_q;
  assign rsp_resp            = rsp_resp_q;
  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = wstrb_q;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master; the bench plays the AXI slave.
// Outputs are sampled on the falling edge, inputs change right after.
module tb_axi_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
`ifdef AXI_LITE_CMD_MASTER_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  axi_lite_cmd_master_if #(.AW(9), .DW(32)) bus ();

  axi_lite_cmd_master dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .m_axi         (bus.master)
`ifdef AXI_LITE_CMD_MASTER_ERR_CNT_EN
    ,
    .err_count     (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    rsp_ready = 1'b1;
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BRESP   = 2'b00;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RDATA   = '0;
    bus.M_AXI_RRESP   = 2'b00;
    bus.M_AXI_RVALID  = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_awvalid", 32'(bus.M_AXI_AWVALID), 32'd0);
    chk("rst_wvalid", 32'(bus.M_AXI_WVALID), 32'd0);
    chk("rst_arvalid", 32'(bus.M_AXI_ARVALID), 32'd0);
    chk("rst_bready", 32'(bus.M_AXI_BREADY), 32'd0);
    chk("rst_rready", 32'(bus.M_AXI_RREADY), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_awaddr", 32'(bus.M_AXI_AWADDR), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
`ifdef AXI_LITE_CMD_MASTER_ERR_CNT_EN
    chk("rst_err_count", 32'(err_count), 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write, zero-wait slave
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 9'h004;
    cmd_wdata = 32'h0000_0003;
    cmd_wstrb = 4'hF;
    bus.M_AXI_AWREADY = 1'b1;
    bus.M_AXI_WREADY  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("w1_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("w1_awvalid", 32'(bus.M_AXI_AWVALID), 32'd1);
    chk("w1_wvalid", 32'(bus.M_AXI_WVALID), 32'd1);
    chk("w1_awaddr", 32'(bus.M_AXI_AWADDR), 32'h004);
    chk("w1_wdata", bus.M_AXI_WDATA, 32'h0000_0003);
    chk("w1_wstrb", 32'(bus.M_AXI_WSTRB), 32'hF);
    chk("w1_bready_lo", 32'(bus.M_AXI_BREADY), 32'd0);
    tick();
    chk("w1_awvalid_drop", 32'(bus.M_AXI_AWVALID), 32'd0);
    chk("w1_wvalid_drop", 32'(bus.M_AXI_WVALID), 32'd0);
    chk("w1_bready", 32'(bus.M_AXI_BREADY), 32'd1);
    bus.M_AXI_BVALID = 1'b1;
    bus.M_AXI_BRESP  = 2'b00;
    tick();
    bus.M_AXI_BVALID = 1'b0;
    chk("w1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("w1_rsp_write", 32'(rsp_write), 32'd1);
    chk("w1_rsp_resp", 32'(rsp_resp), 32'd0);
    chk("w1_rsp_rdata", rsp_rdata, 32'd0);
    chk("w1_bready_drop", 32'(bus.M_AXI_BREADY), 32'd0);
    tick();
    chk("w1_rsp_done", 32'(rsp_valid), 32'd0);
    chk("w1_loop4", 32'(cmd_ready), 32'd1);

    // Read with 3 wait cycles on R
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 9'h008;
    tick();
    cmd_valid = 1'b0;
    chk("r1_arvalid", 32'(bus.M_AXI_ARVALID), 32'd1);
    chk("r1_araddr", 32'(bus.M_AXI_ARADDR), 32'h008);
    chk("r1_awvalid_lo", 32'(bus.M_AXI_AWVALID), 32'd0);
    tick();
    chk("r1_arvalid_hold", 32'(bus.M_AXI_ARVALID), 32'd1);
    chk("r1_araddr_hold", 32'(bus.M_AXI_ARADDR), 32'h008);
    bus.M_AXI_ARREADY = 1'b1;
    tick();
    bus.M_AXI_ARREADY = 1'b0;
    chk("r1_arvalid_drop", 32'(bus.M_AXI_ARVALID), 32'd0);
    chk("r1_rready", 32'(bus.M_AXI_RREADY), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r1_rready_wait", 32'(bus.M_AXI_RREADY), 32'd1);
      chk("r1_rsp_wait", 32'(rsp_valid), 32'd0);
    end
    bus.M_AXI_RVALID = 1'b1;
    bus.M_AXI_RDATA  = 32'hDEAD_BEEF;
    bus.M_AXI_RRESP  = 2'b00;
    tick();
    bus.M_AXI_RVALID = 1'b0;
    chk("r1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("r1_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("r1_rsp_resp", 32'(rsp_resp), 32'd0);
    chk("r1_rsp_write", 32'(rsp_write), 32'd0);
    chk("r1_rready_drop", 32'(bus.M_AXI_RREADY), 32'd0);
    tick();
    chk("r1_cmd_ready", 32'(cmd_ready), 32'd1);

    // Skewed write: W immediate, AW after 5 cycles
    bus.M_AXI_WREADY = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 9'h00C;
    cmd_wdata = 32'h0000_0055;
    cmd_wstrb = 4'h1;
    tick();
    cmd_valid = 1'b0;
    chk("sk_awvalid", 32'(bus.M_AXI_AWVALID), 32'd1);
    chk("sk_wvalid", 32'(bus.M_AXI_WVALID), 32'd1);
    tick();
    chk("sk_wvalid_drop", 32'(bus.M_AXI_WVALID), 32'd0);
    chk("sk_awvalid_hold", 32'(bus.M_AXI_AWVALID), 32'd1);
    chk("sk_bready_lo", 32'(bus.M_AXI_BREADY), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sk_awvalid_wait", 32'(bus.M_AXI_AWVALID), 32'd1);
      chk("sk_awaddr_wait", 32'(bus.M_AXI_AWADDR), 32'h00C);
      chk("sk_bready_wait", 32'(bus.M_AXI_BREADY), 32'd0);
    end
    bus.M_AXI_AWREADY = 1'b1;
    tick();
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    chk("sk_awvalid_drop", 32'(bus.M_AXI_AWVALID), 32'd0);
    chk("sk_bready", 32'(bus.M_AXI_BREADY), 32'd1);
    bus.M_AXI_BVALID = 1'b1;
    tick();
    bus.M_AXI_BVALID = 1'b0;
    chk("sk_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sk_rsp_write", 32'(rsp_write), 32'd1);
    tick();
    chk("sk_cmd_ready", 32'(cmd_ready), 32'd1);

    // Error response three times, BVALID held early by the slave
    bus.M_AXI_AWREADY = 1'b1;
    bus.M_AXI_WREADY  = 1'b1;
    bus.M_AXI_BVALID  = 1'b1;
    bus.M_AXI_BRESP   = 2'b10;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 9'h010;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("er_bready", 32'(bus.M_AXI_BREADY), 32'd1);
      tick();
      chk("er_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("er_rsp_resp", 32'(rsp_resp), 32'h2);
      tick();
      chk("er_cmd_ready", 32'(cmd_ready), 32'd1);
    end
    bus.M_AXI_BVALID = 1'b0;
    bus.M_AXI_BRESP  = 2'b00;
`ifdef AXI_LITE_CMD_MASTER_ERR_CNT_EN
    chk("er_err_count", 32'(err_count), 32'd3);
`endif

    // Backpressure on rsp with a new command waiting
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_ARREADY = 1'b1;
    bus.M_AXI_RVALID  = 1'b1;
    bus.M_AXI_RDATA   = 32'h1234_5678;
    bus.M_AXI_RRESP   = 2'b01;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 9'h014;
    tick();
    cmd_write = 1'b1;
    cmd_addr  = 9'h020;
    cmd_wdata = 32'hA5A5_A5A5;
    cmd_wstrb = 4'h3;
    tick();
    bus.M_AXI_ARREADY = 1'b0;
    tick();
    bus.M_AXI_RVALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
      chk("bp_rsp_resp", 32'(rsp_resp), 32'h1);
      chk("bp_rsp_write", 32'(rsp_write), 32'd0);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_awvalid", 32'(bus.M_AXI_AWVALID), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_rsp_done", 32'(rsp_valid), 32'd0);
    chk("bp_cmd_ready_up", 32'(cmd_ready), 32'd1);
    chk("bp_not_yet", 32'(bus.M_AXI_AWVALID), 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("bp_awvalid", 32'(bus.M_AXI_AWVALID), 32'd1);
    chk("bp_awaddr", 32'(bus.M_AXI_AWADDR), 32'h020);
    chk("bp_wdata", bus.M_AXI_WDATA, 32'hA5A5_A5A5);
    chk("bp_wstrb", 32'(bus.M_AXI_WSTRB), 32'h3);
    bus.M_AXI_AWREADY = 1'b1;
    bus.M_AXI_WREADY  = 1'b1;
    tick();
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BVALID  = 1'b1;
    tick();
    bus.M_AXI_BVALID = 1'b0;
    chk("bp_w_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_w_rsp_rdata", rsp_rdata, 32'd0);
    chk("bp_w_rsp_write", 32'(rsp_write), 32'd1);
    tick();
    chk("bp_w_cmd_ready", 32'(cmd_ready), 32'd1);

    // Reset while ARVALID is high
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 9'h1FC;
    tick();
    cmd_valid = 1'b0;
    chk("rr_arvalid", 32'(bus.M_AXI_ARVALID), 32'd1);
    chk("rr_araddr", 32'(bus.M_AXI_ARADDR), 32'h1FC);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_arvalid_0", 32'(bus.M_AXI_ARVALID), 32'd0);
    chk("rr_araddr_0", 32'(bus.M_AXI_ARADDR), 32'd0);
    chk("rr_cmd_ready_0", 32'(cmd_ready), 32'd0);
    chk("rr_rsp_valid_0", 32'(rsp_valid), 32'd0);
    chk("rr_rsp_rdata_0", rsp_rdata, 32'd0);
`ifdef AXI_LITE_CMD_MASTER_ERR_CNT_EN
    chk("rr_err_count_0", 32'(err_count), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    bus.M_AXI_ARREADY = 1'b1;
    bus.M_AXI_RVALID  = 1'b1;
    tick();
    chk("rr_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_no_rsp", 32'(rsp_valid), 32'd0);
      chk("rr_no_ar", 32'(bus.M_AXI_ARVALID), 32'd0);
    end
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RVALID  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
